// File: rtl/gol_pkg.sv
// Shared types and constants for the video memory: scanner states, default
// frame geometry and the 2-2-2 RGB field layout of a pixel word.
package gol_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN
   } scan_state_e;

   localparam int DEF_VID_BASE = 212;
   localparam int DEF_VID_W    = 20;
   localparam int DEF_VID_H    = 15;

   localparam int PIX_FIELD_W = 2;
   localparam int PIX_R_LSB   = 4;
   localparam int PIX_G_LSB   = 2;
   localparam int PIX_B_LSB   = 0;

endpackage

// File: rtl/gol_dpram.sv
// Dual-port RAM: port A read/write for the CPU, port B read-only for video.
// Both reads are registered and enabled, so each output holds until its next read.
module gol_dpram #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 8,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              we_a,
   input  logic              re_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              re_b,
   input  logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] rdata_b
);

   // NOTE: no reset on the array or its read registers, so it maps onto block RAM and keeps its contents across rst_n.
   logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

   // NOTE: non-blocking writes make port B read-first against a same-cycle port A write.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (re_a) rdata_a <= mem[addr_a];
   end

   always_ff @(posedge clk) begin
      if (re_b) rdata_b <= mem[addr_b];
   end

endmodule

// File: rtl/gol_vmem.sv
// Video memory: CPU-accessible word array plus a raster scanner streaming the
// frame out over a valid/ready port, one pixel per cycle when unstalled.
module gol_vmem
   import gol_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 8,
   parameter int VID_BASE  = DEF_VID_BASE,
   parameter int VID_W     = DEF_VID_W,
   parameter int VID_H     = DEF_VID_H,
   parameter     INIT_FILE = ""
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [ADDR_W-1:0]          cpu_addr,
   input  logic [DATA_W-1:0]          cpu_wdata,
   output logic [DATA_W-1:0]          cpu_rdata,
   output logic                       cpu_rvalid,
   input  logic                       vid_start,
   input  logic                       vid_ready,
   output logic                       vid_valid,
   output logic [DATA_W-1:0]          vid_pixel,
   output logic [$clog2(VID_W)-1:0]   vid_x,
   output logic [$clog2(VID_H)-1:0]   vid_y,
   output logic                       vid_eof,
   output logic                       vid_busy
);

   localparam int                X_W    = $clog2(VID_W);
   localparam int                Y_W    = $clog2(VID_H);
   localparam logic [X_W-1:0]    X_LAST = X_W'(VID_W - 1);
   localparam logic [Y_W-1:0]    Y_LAST = Y_W'(VID_H - 1);
   localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(VID_BASE);

   scan_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [X_W-1:0]    x_q, x_d, out_x_q, out_x_d;
   logic [Y_W-1:0]    y_q, y_d, out_y_q, out_y_d;
   logic              out_valid_q, out_valid_d;
   logic              out_eof_q, out_eof_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              rd_seen_q, rd_seen_d;

   logic              cpu_rd, accept, issue_last, restart, ren;
   logic [DATA_W-1:0] ram_a_rdata, ram_b_rdata;

   assign cpu_rd     = cpu_req & ~cpu_we;
   assign accept     = out_valid_q & vid_ready;
   assign issue_last = (x_q == X_LAST) && (y_q == Y_LAST);
   assign restart    = vid_start && ((state_q == ST_IDLE) || (state_q == ST_DRAIN && accept));

   // The RAM's port B register is the output stage; a new read is issued only
   // when that stage is empty or being drained, so a stall freezes it in place.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      x_d          = x_q;
      y_d          = y_q;
      out_valid_d  = out_valid_q & ~vid_ready;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      out_eof_d    = out_eof_q;
      ren          = 1'b0;
      cpu_rvalid_d = cpu_rd;
      rd_seen_d    = rd_seen_q | cpu_rd;

      unique case (state_q)
         ST_IDLE: ;
         ST_SCAN: begin
            ren = ~out_valid_q | vid_ready;
            if (ren) begin
               out_valid_d = 1'b1;
               out_x_d     = x_q;
               out_y_d     = y_q;
               out_eof_d   = issue_last;
               ptr_d       = ptr_q + 1'b1;
               if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               if (issue_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (accept) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (restart) begin
         state_d = ST_SCAN;
         ptr_d   = BASE;
         x_d     = '0;
         y_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         out_valid_q  <= 1'b0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         out_eof_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         rd_seen_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         x_q          <= x_d;
         y_q          <= y_d;
         out_valid_q  <= out_valid_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         out_eof_q    <= out_eof_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         rd_seen_q    <= rd_seen_d;
      end
   end

   gol_dpram #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .we_a    (cpu_req & cpu_we),
      .re_a    (cpu_rd),
      .addr_a  (cpu_addr),
      .wdata_a (cpu_wdata),
      .rdata_a (ram_a_rdata),
      .re_b    (ren),
      .addr_b  (ptr_q),
      .rdata_b (ram_b_rdata)
   );

   // RAM read registers are not reset, so their outputs are masked until meaningful.
   assign cpu_rdata  = rd_seen_q ? ram_a_rdata : '0;
   assign cpu_rvalid = cpu_rvalid_q;
   assign vid_valid  = out_valid_q;
   assign vid_pixel  = out_valid_q ? ram_b_rdata : '0;
   assign vid_x      = out_x_q;
   assign vid_y      = out_y_q;
   assign vid_eof    = out_valid_q & out_eof_q;
   assign vid_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gol_vmem.sv
// Self-checking bench for gol_vmem: CPU vector table, then frame scans checked
// against a shadow memory through a pixel scoreboard queue.
module tb_gol_vmem;

   localparam int ADDR_W   = 9;
   localparam int DATA_W   = 8;
   localparam int VID_BASE = 212;
   localparam int VID_W    = 20;
   localparam int VID_H    = 15;
   localparam int X_W      = $clog2(VID_W);
   localparam int Y_W      = $clog2(VID_H);
   localparam int N_PIX    = VID_W * VID_H;

   typedef struct packed {
      logic [DATA_W-1:0] pix;
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
      logic              eof;
   } pix_t;

   typedef struct {
      int                addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
   } cpu_vec_t;

   logic              clk, rst_n;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              cpu_rvalid;
   logic              vid_start, vid_ready, vid_valid, vid_eof, vid_busy;
   logic [DATA_W-1:0] vid_pixel;
   logic [X_W-1:0]    vid_x;
   logic [Y_W-1:0]    vid_y;

   logic [DATA_W-1:0] mdl [0:2**ADDR_W-1];
   pix_t              sb[$];
   int                n_cmp = 0;
   int                n_bad = 0;

   gol_vmem #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .VID_BASE (VID_BASE),
      .VID_W    (VID_W),
      .VID_H    (VID_H)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .vid_start  (vid_start),
      .vid_ready  (vid_ready),
      .vid_valid  (vid_valid),
      .vid_pixel  (vid_pixel),
      .vid_x      (vid_x),
      .vid_y      (vid_y),
      .vid_eof    (vid_eof),
      .vid_busy   (vid_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cpu_write(input int addr, input logic [DATA_W-1:0] data);
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = ADDR_W'(addr);
      cpu_wdata = data;
      step();
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      mdl[addr] = data;
   endtask

   task automatic cpu_read_check(input string name, input int addr, input logic [DATA_W-1:0] exp);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = ADDR_W'(addr);
      step();
      cpu_req  = 1'b0;
      check({name, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
      check({name, "_rdata"}, 32'(cpu_rdata), 32'(exp));
      step();
      check({name, "_rvalid_drop"}, 32'(cpu_rvalid), 32'd0);
      check({name, "_rdata_hold"}, 32'(cpu_rdata), 32'(exp));
   endtask

   task automatic push_frame();
      for (int y = 0; y < VID_H; y++) begin
         for (int x = 0; x < VID_W; x++) begin
            int   a;
            pix_t p;
            a     = VID_BASE + y * VID_W + x;
            p.pix = mdl[a];
            p.x   = X_W'(x);
            p.y   = Y_W'(y);
            p.eof = (x == VID_W - 1) && (y == VID_H - 1);
            sb.push_back(p);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
      check({tag, "_vvalid"}, 32'(vid_valid), 32'd0);
      check({tag, "_eof"}, 32'(vid_eof), 32'd0);
      check({tag, "_busy"}, 32'(vid_busy), 32'd0);
      check({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
      check({tag, "_pixel"}, 32'(vid_pixel), 32'd0);
   endtask

   // Drives one frame (or two when chained) and compares every accepted pixel.
   task automatic run_frame(input bit rnd, input bit cpu_hit, input int abort_at,
                            input bit mid_start, input bit chain);
      int   acc, cyc, first_valid, run, max_run, chain_cyc;
      bit   prev_stall, mid_done, chained;
      pix_t prev, cur, exp;
      acc = 0; cyc = 0; first_valid = -1; run = 0; max_run = 0; chain_cyc = -10;
      prev_stall = 1'b0; mid_done = 1'b0; chained = 1'b0; prev = '0;
      sb.delete();
      push_frame();
      vid_start = 1'b1;
      vid_ready = 1'b1;
      step();
      vid_start = 1'b0;
      check("start_busy", 32'(vid_busy), 32'd1);
      if (cpu_hit) begin
         cpu_req   = 1'b1;
         cpu_we    = 1'b1;
         cpu_addr  = ADDR_W'(VID_BASE);
         cpu_wdata = 8'h3F;
         mdl[VID_BASE] = 8'h3F;
      end
      while (sb.size() > 0 && cyc < 4000) begin
         if (abort_at >= 0 && acc == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            sb.delete();
            return;
         end
         vid_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         vid_start = 1'b0;
         if (mid_start && !mid_done && acc == 100) begin
            vid_start = 1'b1;
            mid_done  = 1'b1;
         end
         if (chain && !chained && vid_valid && vid_ready && vid_eof) begin
            vid_start = 1'b1;
            chained   = 1'b1;
            chain_cyc = cyc;
            push_frame();
         end
         #1;
         cur = {vid_pixel, vid_x, vid_y, vid_eof};
         if (prev_stall) check("stall_hold", {13'd0, vid_valid, cur}, {13'd0, 1'b1, prev});
         if (cyc == chain_cyc + 1) check("chain_busy", 32'(vid_busy), 32'd1);
         if (cyc == chain_cyc + 2) check("chain_first_valid", 32'(vid_valid), 32'd1);
         if (vid_valid) begin
            run++;
            if (first_valid < 0) first_valid = cyc;
         end else begin
            run = 0;
         end
         if (run > max_run) max_run = run;
         if (vid_valid && vid_ready) begin
            exp = sb.pop_front();
            check($sformatf("pix%0d", acc), 32'(cur), 32'(exp));
            acc++;
         end
         prev_stall = vid_valid && !vid_ready;
         prev       = cur;
         cyc++;
         step();
         cpu_req = 1'b0;
         cpu_we  = 1'b0;
      end
      check("frame_timeout", 32'(sb.size()), 32'd0);
      check("first_valid_latency", 32'(first_valid), 32'd1);
      if (!rnd && !chain) check("run_length", 32'(max_run), 32'(N_PIX));
      check("end_busy", 32'(vid_busy), 32'd0);
      check("end_valid", 32'(vid_valid), 32'd0);
      vid_ready = 1'b1;
      repeat (3) step();
      check("idle_quiet", {30'd0, vid_valid, vid_busy}, 32'd0);
   endtask

   initial begin
      cpu_vec_t vecs[5];
      bit       leaked;
      vecs[0] = '{5,   8'h2A, 8'h2A};
      vecs[1] = '{0,   8'h55, 8'h55};
      vecs[2] = '{211, 8'hFF, 8'hFF};
      vecs[3] = '{100, 8'hC3, 8'hC3};
      vecs[4] = '{5,   8'h15, 8'h15};

      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      vid_start = 1'b0;
      vid_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) begin
         cpu_write(vecs[i].addr, vecs[i].wdata);
         cpu_read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata);
      end

      for (int a = VID_BASE; a < VID_BASE + N_PIX; a++) begin
         logic [31:0] av;
         av = 32'(a);
         cpu_write(a, av[7:0]);
      end

      run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
      run_frame(1'b1, 1'b0, -1, 1'b0, 1'b0);
      run_frame(1'b0, 1'b1, -1, 1'b0, 1'b0);
      cpu_read_check("rd_collide", VID_BASE, 8'h3F);

      run_frame(1'b0, 1'b0, 150, 1'b0, 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      vid_ready = 1'b1;
      vid_start = 1'b0;
      leaked    = 1'b0;
      repeat (10) begin
         step();
         if (vid_valid || vid_busy) leaked = 1'b1;
      end
      check("post_abort_quiet", 32'(leaked), 32'd0);
      cpu_read_check("post_abort_212", VID_BASE, mdl[VID_BASE]);
      cpu_read_check("post_abort_362", 362, mdl[362]);
      cpu_read_check("post_abort_5", 5, mdl[5]);
      run_frame(1'b1, 1'b0, -1, 1'b0, 1'b0);

      run_frame(1'b1, 1'b0, -1, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gol_vmem.md
GOL_VMEM -- requirements
Module: gol_vmem

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the word address width; depth is 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, SHALL set the word width; pixel format is 2b R, 2b G, 2b B in bits 5:0, and upper bits are ignored by the display.
REQ-003 Parameter VID_BASE, default 212, SHALL give the word address of pixel (0,0).
REQ-004 Parameters VID_W, default 20, and VID_H, default 15, SHALL give the frame size in pixels; VID_BASE+VID_W*VID_H <= depth.
REQ-005 Parameter INIT_FILE, default "" (none), SHALL name a hex file loaded into the array at elaboration.
REQ-006 Ports SHALL be, as name / direction / width / meaning:
- clk / in / 1 / single clock; all state changes on rising edge.
- rst_n / in / 1 / asynchronous, active-low reset.
- cpu_req / in / 1 / CPU access this cycle.
- cpu_we / in / 1 / 1 = write, 0 = read.
- cpu_addr / in / ADDR_W / word address.
- cpu_wdata / in / DATA_W / write data.
- cpu_rdata / out / DATA_W / read data.
- cpu_rvalid / out / 1 / cpu_rdata valid.
- vid_start / in / 1 / frame-start pulse.
- vid_ready / in / 1 / sink accepts pixel.
- vid_valid / out / 1 / pixel offered.
- vid_pixel / out / DATA_W / pixel value.
- vid_x / out / clog2(VID_W) / column of offered pixel.
- vid_y / out / clog2(VID_H) / row of offered pixel.
- vid_eof / out / 1 / offered pixel is the last of the frame.
- vid_busy / out / 1 / scan in progress.

Function
REQ-007 A CPU write (cpu_req & cpu_we) SHALL update the array at the clock edge; the CPU port is always ready, with no stall.
REQ-008 A CPU read SHALL return data one cycle later with cpu_rvalid=1 for exactly one cycle; cpu_rdata SHALL hold its value until the next read.
REQ-009 A CPU read issued the cycle after a write to the same address SHALL return the new data.
REQ-010 The video port SHALL be read-first: a video read and a CPU write to the same address in the same cycle SHALL return the old word.
REQ-011 The scanner FSM SHALL have three states:
- IDLE: on vid_start, go to SCAN with pointer = VID_BASE and x = y = 0.
- SCAN: issue synchronous reads; the pixel appears one cycle after its address.
- DRAIN: after the last address is issued, wait until the final pixel is accepted, then go to IDLE.
REQ-012 Pixels SHALL be emitted in raster order: x increments 0..VID_W-1, then x wraps to 0 and y increments; address = VID_BASE + y*VID_W + x, using an incremental pointer with no multiplier.
REQ-013 A transfer SHALL occur when vid_valid & vid_ready.
REQ-014 While vid_valid & !vid_ready, vid_pixel, vid_x, vid_y and vid_eof SHALL hold stable.
REQ-015 No pixel SHALL be dropped or duplicated under any vid_ready pattern; a two-entry skid buffer is permitted.
REQ-016 vid_eof SHALL be 1 only with pixel (VID_W-1, VID_H-1).
REQ-017 vid_busy SHALL be 1 in SCAN and DRAIN.
REQ-018 vid_start received in SCAN or DRAIN SHALL be ignored.
REQ-019 vid_start received in the same cycle as the last pixel's acceptance SHALL start a new frame with no idle cycle.
REQ-020 CPU writes during a scan SHALL be visible to any pixel whose address is read after the write edge, so tearing is permitted.
REQ-021 First vid_valid latency SHALL be 1 cycle after vid_start is sampled in IDLE.
REQ-022 With vid_ready held at 1, throughput SHALL be 1 pixel per cycle.

Reset
REQ-023 rst_n low SHALL immediately force the FSM to IDLE and clear the pointer, x, y and skid state.
REQ-024 rst_n low SHALL immediately force cpu_rvalid, vid_valid, vid_eof and vid_busy to 0, and cpu_rdata and vid_pixel to 0.
REQ-025 Array contents SHALL NOT be reset; they retain INIT_FILE or prior writes.
REQ-026 A reset asserted mid-frame SHALL abort the frame; after release, no pixel is emitted until a new vid_start.

Structure
REQ-027 Package gol_pkg SHALL hold the FSM state enum, the default VID_BASE/VID_W/VID_H constants and the pixel colour field positions.
REQ-028 The array SHALL be a sub-module gol_dpram: one write/read port plus one read-only port, both registered reads, inferable as block RAM.

Verification
REQ-029 Write 0x2A to address 5 via CPU, then read address 5 -> cpu_rvalid one cycle later with cpu_rdata=0x2A.
REQ-030 Load INIT_FILE with word = address[7:0] and pulse vid_start with vid_ready=1 -> 300 pixels 0xD4,0xD5,...; x/y wrap at 19; vid_eof only on (19,14); 300 consecutive valid cycles.
REQ-031 Same frame with vid_ready as a random 50% pattern -> identical 300-pixel sequence; outputs stable during every stall.
REQ-032 CPU write 0x3F to address 212 in the same cycle the scanner reads 212 -> pixel (0,0) is the old value; a later CPU read of 212 returns 0x3F.
REQ-033 Pull rst_n low at pixel 150 -> vid_valid=0 and vid_busy=0 immediately; array contents unchanged; a new vid_start gives a full 300-pixel frame.
REQ-034 Pulse vid_start mid-frame, then again on the cycle of vid_eof acceptance -> the first pulse is ignored and the second frame starts back-to-back.
